// File: rtl/divisor_pkg.sv
// divisor_pkg: shared state encoding and error pattern for the arbitrated divider.
//   IDLE/LOAD/WAIT/RESP : arbiter state encoding
//   ERR_PATTERN         : all-ones word; truncate with W'(ERR_PATTERN)
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_t;

    localparam logic [31:0] ERR_PATTERN = '1;

endpackage

// File: rtl/divisor_core.sv
// divisor_core: start/done repeated-subtraction unsigned divider.
//   clk, rst           : clock, async active-high reset
//   div_start          : one-cycle pulse, latches div_num/div_den
//   div_done           : one-cycle pulse, div_result/div_resto/div_err valid
//   div_err            : den==0, or 0<num<den (outputs forced to all ones)
module divisor_core
    import divisor_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_start,
    input  logic [W-1:0] div_num,
    input  logic [W-1:0] div_den,
    output logic         div_done,
    output logic [W-1:0] div_result,
    output logic [W-1:0] div_resto,
    output logic         div_err
);

    logic         run_q, run_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] den_q, den_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] resto_q, resto_d;
    logic         sub;
    logic         bad;

    assign sub = (rem_q >= den_q) && (den_q != '0);
    // Quotient still zero with a nonzero remainder means 0 < num < den.
    assign bad = (den_q == '0) || ((quo_q == '0) && (rem_q != '0));

    always_comb begin
        run_d   = run_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        res_d   = res_q;
        resto_d = resto_q;
        if (div_start) begin
            run_d = 1'b1;
            rem_d = div_num;
            quo_d = '0;
            den_d = div_den;
        end else if (run_q) begin
            if (sub) begin
                rem_d = rem_q - den_q;
                quo_d = quo_q + 1'b1;
            end else begin
                run_d   = 1'b0;
                done_d  = 1'b1;
                err_d   = bad;
                res_d   = bad ? W'(ERR_PATTERN) : quo_q;
                resto_d = bad ? W'(ERR_PATTERN) : rem_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            res_q   <= '0;
            resto_q <= '0;
        end else begin
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            res_q   <= res_d;
            resto_q <= resto_d;
        end
    end

    assign div_done   = done_q;
    assign div_result = res_q;
    assign div_resto  = resto_q;
    assign div_err    = err_q;

endmodule

// File: rtl/divisor_arbitro.sv
// divisor_arbitro: round-robin arbiter sharing one divisor_core between two requesters.
//   req0/num0/den0, req1/num1/den1 : requests held until the matching ack
//   ack0/ack1                      : one-cycle response pulse
//   result/resto/err               : quotient, remainder, error (hold until next capture)
//   busy                           : high whenever not IDLE
module divisor_arbitro
    import divisor_pkg::*;
#(
    parameter int W       = 4,
    parameter int TIMEOUT = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] num0,
    input  logic [W-1:0] den0,
    input  logic         req1,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] den1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] result,
    output logic [W-1:0] resto,
    output logic         err,
    output logic         busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t       state_q, state_d;
    logic         last_q, last_d;
    logic         gnt_q, gnt_d;
    logic [W-1:0] num_q, num_d;
    logic [W-1:0] den_q, den_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] resto_q, resto_d;
    logic         err_q, err_d;

    logic         div_start;
    logic         div_done;
    logic [W-1:0] div_result;
    logic [W-1:0] div_resto;
    logic         div_err;

    divisor_core #(.W(W)) u_core (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_num    (num_q),
        .div_den    (den_q),
        .div_done   (div_done),
        .div_result (div_result),
        .div_resto  (div_resto),
        .div_err    (div_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            num_q    <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            resto_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            num_q    <= num_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            resto_q  <= resto_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        num_d    = num_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        resto_d  = resto_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the requester not served last time wins.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    num_d   = gnt_d ? num1 : num0;
                    den_d   = gnt_d ? den1 : den0;
                    last_d  = gnt_d;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (den_q == '0) begin
                    err_d    = 1'b1;
                    result_d = W'(ERR_PATTERN);
                    resto_d  = W'(ERR_PATTERN);
                    state_d  = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // done is tested first so it wins over a same-cycle timeout.
                if (div_done) begin
                    err_d    = div_err;
                    result_d = div_result;
                    resto_d  = div_resto;
                    state_d  = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    result_d = W'(ERR_PATTERN);
                    resto_d  = W'(ERR_PATTERN);
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_start = (state_q == LOAD) && (den_q != '0);
        ack0      = (state_q == RESP) && !gnt_q;
        ack1      = (state_q == RESP) && gnt_q;
        busy      = state_q != IDLE;
    end

    assign result = result_q;
    assign resto  = resto_q;
    assign err    = err_q;

endmodule
